// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad front end: FSM state encoding,
// lowest-set-bit resolver and the default 4x4 hex legend for downstream encoders.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_SCAN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HELD     = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_REPEAT   = 3'd4
  } scan_state_t;

  localparam int STATE_W = 3;

  // Indexed by row*4+col: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D  (* = E, # = F)
  localparam logic [15:0][3:0] KEY_HEX_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic int lowest_set(input logic [31:0] v);
    lowest_set = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set = i;
    end
  endfunction

endpackage

// File: rtl/keypad_stable_cnt.sv
// Saturating stability counter; done holds once DB_CYCLES-1 consecutive increments
// have been seen since the last clear.
module keypad_stable_cnt #(
  parameter int DB_CYCLES = 600
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic done
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == CW'(DB_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)              cnt_d = '0;
    else if (inc && !done) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan_entry.sv
// R x C keypad scanner with column synchroniser, press/release debounce and a
// DIGITS-deep key history. Define KEY_REPEAT_EN to add auto-repeat while a key is held.
module keypad_scan_entry
  import keypad_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int DIGITS    = 2,
  parameter int SCAN_DIV  = 6000,
  parameter int DB_CYCLES = 600,
`ifdef KEY_REPEAT_EN
  parameter int REPEAT_DLY = 3_000_000,
  parameter int REPEAT_PER = 600_000,
`endif
  localparam int KW = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [COLS-1:0]      col_i,
  output logic [ROWS-1:0]      row_o,
  output logic                 key_valid_o,
  output logic [KW-1:0]        key_idx_o,
  output logic [DIGITS*KW-1:0] hist_o,
  output logic [DIGITS-1:0]    hist_vld_o,
  output logic [2:0]           state_o
);
  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int HW = DIGITS*KW;

  logic [COLS-1:0]   sync1_q, sync2_q, col_s;
  scan_state_t       state_q, state_d;
  logic [RW-1:0]     row_q, row_d, nxt_row;
  logic [ROWS-1:0]   row_o_q, row_o_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [COLS-1:0]   cap_q, cap_d;
  logic              key_vld_q, key_vld_d;
  logic [KW-1:0]     key_idx_q, key_idx_d, key_new;
  logic [HW-1:0]     hist_q, hist_d;
  logic [DIGITS-1:0] hist_vld_q, hist_vld_d;
  logic              accept, db_clr, db_inc, db_done;

`ifdef KEY_REPEAT_EN
  localparam int RPMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RPW   = $clog2(RPMAX + 1);
  logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // Pins are pulled up; a pressed key on the driven row reads as 0.
  assign col_s   = ~sync2_q;
  assign nxt_row = (row_q == RW'(ROWS-1)) ? '0 : row_q + RW'(1);
  assign key_new = KW'(int'(row_q)*COLS + lowest_set(32'(cap_q)));

  keypad_stable_cnt #(.DB_CYCLES(DB_CYCLES)) u_stable (
    .clk  (clk),
    .rstn (rstn),
    .clr  (db_clr),
    .inc  (db_inc),
    .done (db_done)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    scan_cnt_d = scan_cnt_q;
    cap_d      = cap_q;
    accept     = 1'b0;
    db_clr     = 1'b0;
    db_inc     = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif
    case (state_q)
      ST_SCAN: begin
        // Sample only on the last cycle so the row has settled through the synchroniser.
        if (scan_cnt_q == SW'(SCAN_DIV-1)) begin
          scan_cnt_d = '0;
          if (col_s == '0) row_d = nxt_row;
          else begin
            cap_d   = col_s;
            db_clr  = 1'b1;
            state_d = ST_DEBOUNCE;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (col_s == '0) begin
          state_d = ST_SCAN;
          row_d   = nxt_row;
        end else if (col_s != cap_q) begin
          cap_d  = col_s;
          db_clr = 1'b1;
        end else if (db_done) begin
          accept  = 1'b1;
          state_d = ST_HELD;
`ifdef KEY_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end else begin
          db_inc = 1'b1;
        end
      end
      ST_HELD: begin
        if (col_s == '0) begin
          state_d = ST_RELEASE;
          db_clr  = 1'b1;
        end
`ifdef KEY_REPEAT_EN
        else if (rep_cnt_q == RPW'(REPEAT_DLY-1)) begin
          state_d   = ST_REPEAT;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RPW'(1);
        end
`endif
      end
      ST_RELEASE: begin
        if (col_s != '0) begin
          state_d = ST_HELD;
`ifdef KEY_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end else if (db_done) begin
          state_d = ST_SCAN;
          row_d   = nxt_row;
        end else begin
          db_inc = 1'b1;
        end
      end
`ifdef KEY_REPEAT_EN
      ST_REPEAT: begin
        if (col_s == '0) begin
          state_d = ST_RELEASE;
          db_clr  = 1'b1;
        end else if (rep_cnt_q == RPW'(REPEAT_PER-1)) begin
          accept    = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RPW'(1);
        end
      end
`endif
      default: state_d = ST_SCAN;
    endcase

    row_o_d    = ~(ROWS'(1) << row_d);
    key_vld_d  = accept;
    key_idx_d  = accept ? key_new : key_idx_q;
    hist_d     = accept ? HW'({hist_q, key_new}) : hist_q;
    hist_vld_d = accept ? DIGITS'({hist_vld_q, 1'b1}) : hist_vld_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      state_q    <= ST_SCAN;
      row_q      <= '0;
      row_o_q    <= ~ROWS'(1);
      scan_cnt_q <= '0;
      cap_q      <= '0;
      key_vld_q  <= 1'b0;
      key_idx_q  <= '0;
      hist_q     <= '0;
      hist_vld_q <= '0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      sync1_q    <= col_i;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      row_q      <= row_d;
      row_o_q    <= row_o_d;
      scan_cnt_q <= scan_cnt_d;
      cap_q      <= cap_d;
      key_vld_q  <= key_vld_d;
      key_idx_q  <= key_idx_d;
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
`ifdef KEY_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign row_o       = row_o_q;
  assign key_valid_o = key_vld_q;
  assign key_idx_o   = key_idx_q;
  assign hist_o      = hist_q;
  assign hist_vld_o  = hist_vld_q;
  assign state_o     = state_q;

endmodule
